regfile_wb_arb: RTL and testbench

- Write-side front end for the 2-read/1-write integer register file.
- Collects results from two producers: source 0 = ALU/execute, source 1 = LSU load return. Each producer uses a valid/ready handshake.
- Per-source FIFOs buffer the results; a round-robin arbiter serialises them onto the register file's single registered write port.
- Exports a pending-destination mask for the decode hazard logic, so operands are not read from the register file before their write has landed.

---
 rtl/regfile_wb_arb_pkg.sv | 21 ++
 rtl/regfile_wb_arb_if.sv | 34 +++
 rtl/regfile_wb_arb_fifo.sv | 82 ++++++++
 rtl/regfile_wb_arb.sv | 138 +++++++++++++
 tb/tb_regfile_wb_arb.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arb_pkg.sv
// Shared types for the register-file write-back front end (package regfile_pkg).
package regfile_pkg;

    localparam int DLEN_DEF = 32;
    localparam int ALEN_DEF = 5;

    typedef struct packed {
        logic [ALEN_DEF-1:0] rd;
        logic [DLEN_DEF-1:0] data;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    function automatic wb_src_e wb_other(input wb_src_e s);
        return (s == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Producer handshakes, register-file write port and busy mask of regfile_wb_arb.
interface regfile_wb_arb_if
    import regfile_pkg::*;
#(
    parameter int DLEN = DLEN_DEF,
    parameter int ALEN = ALEN_DEF
);
    logic                 i_alu_valid;
    logic                 o_alu_ready;
    logic [ALEN-1:0]      i_alu_rd;
    logic [DLEN-1:0]      i_alu_data;
    logic                 i_lsu_valid;
    logic                 o_lsu_ready;
    logic [ALEN-1:0]      i_lsu_rd;
    logic [DLEN-1:0]      i_lsu_data;
    logic                 o_wen;
    logic [ALEN-1:0]      o_waddr;
    logic [DLEN-1:0]      o_wdata;
    logic [(1<<ALEN)-1:0] o_busy_mask;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_data,
        input  o_alu_ready, o_lsu_ready,
        input  o_wen, o_waddr, o_wdata, o_busy_mask
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_data,
        output o_alu_ready, o_lsu_ready,
        output o_wen, o_waddr, o_wdata, o_busy_mask
    );
endinterface

// File: rtl/regfile_wb_arb_fifo.sv
// wb_fifo: synchronous circular FIFO of wb_req_t with per-slot valid/rd taps
// so the parent can build a destination-busy mask.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  wb_req_t                        push_data_i,
    input  logic                           pop_i,
    output wb_req_t                        head_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic [DEPTH-1:0]               entry_valid_o,
    output logic [DEPTH-1:0][ALEN_DEF-1:0] entry_rd_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t          mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Push only targets an empty slot and pop only the head, so the two
    // valid-bit updates never collide even when both happen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (do_push) begin
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        entry_rd_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_rd_o[i] = mem_q[i].rd;
        end
    end

    assign head_o        = mem_q[rd_ptr_q];
    assign full_o        = (count_q == CW'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign entry_valid_o = vld_q;

endmodule

// File: rtl/regfile_wb_arb.sv
// Write-back front end: two buffered producers round-robined onto one registered
// register-file write port. Define REGFILE_WB_ARB_BYPASS_EN for the 1-cycle path.
module regfile_wb_arb
    import regfile_pkg::*;
#(
    parameter int DLEN  = DLEN_DEF,
    parameter int ALEN  = ALEN_DEF,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    regfile_wb_arb_if.slave  bus
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int NREG = 1 << ALEN;

    wb_req_t                        alu_req, lsu_req, alu_head, lsu_head, sel_req;
    logic                           alu_full, alu_empty, lsu_full, lsu_empty;
    logic [CW-1:0]                  alu_count, lsu_count;
    logic [DEPTH-1:0]               alu_vld, lsu_vld;
    logic [DEPTH-1:0][ALEN_DEF-1:0] alu_rds, lsu_rds;
    logic                           alu_ready, lsu_ready;
    logic                           alu_live, lsu_live;
    logic                           alu_push, lsu_push, alu_pop, lsu_pop;
    logic                           sel_vld;
    wb_src_e                        sel_src;
    wb_src_e                        last_q;
    logic                           wen_q;
    logic [ALEN-1:0]                waddr_q;
    logic [DLEN-1:0]                wdata_q;
    logic [NREG-1:0]                busy_mask;

    assign alu_ready = (alu_count < CW'(DEPTH));
    assign lsu_ready = (lsu_count < CW'(DEPTH));

    // Writes to x0 complete the handshake but are discarded here.
    assign alu_live = bus.i_alu_valid & alu_ready & (bus.i_alu_rd != '0);
    assign lsu_live = bus.i_lsu_valid & lsu_ready & (bus.i_lsu_rd != '0);

    assign alu_req = '{rd: bus.i_alu_rd, data: bus.i_alu_data};
    assign lsu_req = '{rd: bus.i_lsu_rd, data: bus.i_lsu_data};

    always_comb begin
        sel_vld  = 1'b0;
        sel_src  = WB_SRC_ALU;
        sel_req  = alu_head;
        alu_pop  = 1'b0;
        lsu_pop  = 1'b0;
        alu_push = alu_live & ~alu_full;
        lsu_push = lsu_live & ~lsu_full;
        if (!alu_empty || !lsu_empty) begin
            sel_vld = 1'b1;
            if (!alu_empty && !lsu_empty) begin
                sel_src = wb_other(last_q);
            end else begin
                sel_src = alu_empty ? WB_SRC_LSU : WB_SRC_ALU;
            end
            sel_req = (sel_src == WB_SRC_LSU) ? lsu_head : alu_head;
            alu_pop = (sel_src == WB_SRC_ALU);
            lsu_pop = (sel_src == WB_SRC_LSU);
        end
`ifdef REGFILE_WB_ARB_BYPASS_EN
        else if (alu_live || lsu_live) begin
            sel_vld = 1'b1;
            if (alu_live && lsu_live) begin
                sel_src = wb_other(last_q);
            end else begin
                sel_src = alu_live ? WB_SRC_ALU : WB_SRC_LSU;
            end
            sel_req  = (sel_src == WB_SRC_LSU) ? lsu_req : alu_req;
            alu_push = alu_live & (sel_src != WB_SRC_ALU);
            lsu_push = lsu_live & (sel_src != WB_SRC_LSU);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            last_q  <= WB_SRC_ALU;
        end else begin
            wen_q <= sel_vld;
            if (sel_vld) begin
                waddr_q <= sel_req.rd;
                wdata_q <= sel_req.data;
                last_q  <= sel_src;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_vld[i]) busy_mask[alu_rds[i]] = 1'b1;
            if (lsu_vld[i]) busy_mask[lsu_rds[i]] = 1'b1;
        end
        if (wen_q) busy_mask[waddr_q] = 1'b1;
        busy_mask[0] = 1'b0;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (alu_push),
        .push_data_i   (alu_req),
        .pop_i         (alu_pop),
        .head_o        (alu_head),
        .full_o        (alu_full),
        .empty_o       (alu_empty),
        .count_o       (alu_count),
        .entry_valid_o (alu_vld),
        .entry_rd_o    (alu_rds)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (lsu_push),
        .push_data_i   (lsu_req),
        .pop_i         (lsu_pop),
        .head_o        (lsu_head),
        .full_o        (lsu_full),
        .empty_o       (lsu_empty),
        .count_o       (lsu_count),
        .entry_valid_o (lsu_vld),
        .entry_rd_o    (lsu_rds)
    );

    assign bus.o_alu_ready = alu_ready;
    assign bus.o_lsu_ready = lsu_ready;
    assign bus.o_wen       = wen_q;
    assign bus.o_waddr     = waddr_q;
    assign bus.o_wdata     = wdata_q;
    assign bus.o_busy_mask = busy_mask;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Scoreboard bench for regfile_wb_arb: queue-level reference model, random and directed traffic.
module tb_regfile_wb_arb;
    import regfile_pkg::*;

    localparam int DLEN  = 32;
    localparam int ALEN  = 5;
    localparam int DEPTH = 2;
    localparam int NREG  = 1 << ALEN;

    typedef struct {
        int unsigned rd;
        int unsigned data;
    } item_t;

    logic clk = 1'b0;
    logic rst;

    regfile_wb_arb_if #(.DLEN(DLEN), .ALEN(ALEN)) bus ();

    regfile_wb_arb #(.DLEN(DLEN), .ALEN(ALEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Producer streams, model FIFOs and expected-write scoreboard
    item_t       sa[$], sl[$], qa[$], ql[$], exp_q[$];
    int unsigned seen[$];
    int          last_src;
    bit          m_wen;
    int unsigned m_waddr, m_wdata;
    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    item_t       mon_it;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m;
        m = '0;
        foreach (qa[i]) m[qa[i].rd] = 1'b1;
        foreach (ql[i]) m[ql[i].rd] = 1'b1;
        if (m_wen) m[m_waddr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        qa.delete();
        ql.delete();
        exp_q.delete();
        last_src = 0;
        m_wen    = 1'b0;
        m_waddr  = 0;
        m_wdata  = 0;
    endtask

    // One clock edge of the specified behaviour, applied to the model queues
    task automatic step();
        bit    axf, lxf, alive, llive;
        int    g;
        item_t it;
        if (rst) begin
            model_reset();
            return;
        end
        axf   = (sa.size() > 0) && (qa.size() < DEPTH);
        lxf   = (sl.size() > 0) && (ql.size() < DEPTH);
        alive = axf && (sa[0].rd != 0);
        llive = lxf && (sl[0].rd != 0);
        g = -1;
        if (qa.size() > 0 && ql.size() > 0) g = 1 - last_src;
        else if (qa.size() > 0)             g = 0;
        else if (ql.size() > 0)             g = 1;
        if (g == 0) it = qa.pop_front();
        if (g == 1) it = ql.pop_front();
`ifdef REGFILE_WB_ARB_BYPASS_EN
        if (g < 0 && (alive || llive)) begin
            g  = (alive && llive) ? 1 - last_src : (alive ? 0 : 1);
            it = (g == 0) ? sa[0] : sl[0];
            if (g == 0) alive = 1'b0;
            else        llive = 1'b0;
        end
`endif
        if (g >= 0) begin
            m_wen    = 1'b1;
            m_waddr  = it.rd;
            m_wdata  = it.data;
            last_src = g;
            exp_q.push_back(it);
        end else begin
            m_wen = 1'b0;
        end
        if (alive) qa.push_back(sa[0]);
        if (llive) ql.push_back(sl[0]);
        if (axf) void'(sa.pop_front());
        if (lxf) void'(sl.pop_front());
    endtask

    task automatic drive();
        bus.i_alu_valid = (sa.size() > 0);
        bus.i_alu_rd    = (sa.size() > 0) ? ALEN'(sa[0].rd) : '0;
        bus.i_alu_data  = (sa.size() > 0) ? DLEN'(sa[0].data) : '0;
        bus.i_lsu_valid = (sl.size() > 0);
        bus.i_lsu_rd    = (sl.size() > 0) ? ALEN'(sl[0].rd) : '0;
        bus.i_lsu_data  = (sl.size() > 0) ? DLEN'(sl[0].data) : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        step();
        #1;
        drive();
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a write
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("alu_ready", 64'(bus.o_alu_ready), 64'(qa.size() < DEPTH));
            chk("lsu_ready", 64'(bus.o_lsu_ready), 64'(ql.size() < DEPTH));
            chk("busy_mask", 64'(bus.o_busy_mask), 64'(model_mask()));
            chk("wen", 64'(bus.o_wen), 64'(m_wen));
            if (bus.o_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got waddr %0h expected no write at %0t", bus.o_waddr, $time);
                end else begin
                    mon_it = exp_q.pop_front();
                    chk("waddr", 64'(bus.o_waddr), 64'(mon_it.rd));
                    chk("wdata", 64'(bus.o_wdata), 64'(mon_it.data));
                    seen.push_back(32'(bus.o_waddr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned exp_order[6];
        exp_order = '{8, 1, 9, 2, 10, 3};

        drive();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_wen", 64'(bus.o_wen), 64'd0);
        chk("rst_waddr", 64'(bus.o_waddr), 64'd0);
        chk("rst_wdata", 64'(bus.o_wdata), 64'd0);
        chk("rst_mask", 64'(bus.o_busy_mask), 64'd0);
        chk("rst_alu_ready", 64'(bus.o_alu_ready), 64'd1);
        chk("rst_lsu_ready", 64'(bus.o_lsu_ready), 64'd1);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Single ALU write
        seen.delete();
        sa.push_back(item_t'{5, 32'hDEADBEEF});
        drive();
        drain(6);
        chk("single_count", 64'(seen.size()), 64'd1);
        if (seen.size() > 0) chk("single_rd", 64'(seen[0]), 64'd5);

        // Both sources streaming: interleaving order
        seen.delete();
        for (int unsigned i = 0; i < 3; i++) begin
            sa.push_back(item_t'{1 + i, 32'hA000 + i});
            sl.push_back(item_t'{8 + i, 32'hB000 + i});
        end
        drive();
        drain(12);
        chk("order_count", 64'(seen.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < seen.size()) chk("order_rd", 64'(seen[i]), 64'(exp_order[i]));
        end

        // Write to x0 is accepted and dropped
        seen.delete();
        sl.push_back(item_t'{0, 32'h1234});
        drive();
        drain(5);
        chk("x0_no_write", 64'(seen.size()), 64'd0);
        chk("x0_consumed", 64'(sl.size()), 64'd0);

        // LSU stall: FIFO fills while ALU competes for alternate grants
        seen.delete();
        for (int unsigned i = 0; i < 12; i++) sa.push_back(item_t'{1 + i, $urandom});
        for (int unsigned i = 0; i < 6; i++)  sl.push_back(item_t'{16 + i, $urandom});
        drive();
        drain(30);
        chk("stall_count", 64'(seen.size()), 64'd18);

        // Fill both FIFOs, then reset mid-operation
        for (int unsigned i = 0; i < 4; i++) begin
            sa.push_back(item_t'{3 + i, $urandom});
            sl.push_back(item_t'{12 + i, $urandom});
        end
        drive();
        tick();
        tick();
        tick();
        sa.delete();
        sl.delete();
        drive();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wen", 64'(bus.o_wen), 64'd0);
        chk("post_rst_mask", 64'(bus.o_busy_mask), 64'd0);
        chk("post_rst_alu_ready", 64'(bus.o_alu_ready), 64'd1);
        chk("post_rst_lsu_ready", 64'(bus.o_lsu_ready), 64'd1);
        seen.delete();
        sa.push_back(item_t'{20, 32'h2020});
        sl.push_back(item_t'{21, 32'h2121});
        drive();
        drain(6);
        chk("post_rst_tie_count", 64'(seen.size()), 64'd2);
        if (seen.size() > 0) chk("post_rst_tie_lsu", 64'(seen[0]), 64'd21);

        // Randomised traffic
        for (int n = 0; n < 500; n++) begin
            if (sa.size() == 0 && $urandom_range(0, 99) < 60)
                sa.push_back(item_t'{$urandom_range(0, NREG - 1), $urandom});
            if (sl.size() == 0 && $urandom_range(0, 99) < 60)
                sl.push_back(item_t'{$urandom_range(0, NREG - 1), $urandom});
            drive();
            tick();
        end
        sa.delete();
        sl.delete();
        drive();
        drain(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
